// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: RAW hazard stall, branch flush and SRAM wait/timeout FSM.
// Optional PIPE_PERF_CNT_EN adds four wrapping 32-bit performance counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       forward_en,
  input  logic [3:0] id_src1,
  input  logic [3:0] id_src2,
  input  logic       id_use_src1,
  input  logic       id_two_src,
  input  logic [3:0] exe_dest,
  input  logic       exe_wb_en,
  input  logic       exe_mem_read_en,
  input  logic [3:0] mem_dest,
  input  logic       mem_wb_en,
  input  logic       branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       freeze_if,
  output logic       flush_if,
  output logic       bubble_id,
  output logic       freeze_pipe,
  output logic       mem_start,
  output logic       mem_err,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_flushes,
  output logic [31:0] perf_mem_wait,
`endif
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  // Counter value in the last MEM_WAIT cycle before the access is declared lost.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            haz;
  logic            src1ExeHit, src2ExeHit, src1MemHit, src2MemHit;

  assign src1ExeHit = id_use_src1 & exe_wb_en & (id_src1 == exe_dest);
  assign src2ExeHit = id_two_src  & exe_wb_en & (id_src2 == exe_dest);
  assign src1MemHit = id_use_src1 & mem_wb_en & (id_src1 == mem_dest);
  assign src2MemHit = id_two_src  & mem_wb_en & (id_src2 == mem_dest);

  // With forwarding only a load in EXE cannot be bypassed in time.
  always_comb begin
    if (forward_en) begin
      haz = exe_mem_read_en & (src1ExeHit | src2ExeHit);
    end else begin
      haz = src1ExeHit | src2ExeHit | src1MemHit | src2MemHit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    freeze_pipe = 1'b0;
    mem_start   = 1'b0;
    unique case (state_q)
      RUN: begin
        cnt_d = '0;
        if (mem_req) begin
          mem_start   = 1'b1;
          freeze_pipe = 1'b1;
          state_d     = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          freeze_pipe = 1'b1;
          cnt_d       = cnt_q + TO_W'(1);
          if (cnt_q == TO_LAST) begin
            state_d = ERROR;
          end
        end
      end
      ERROR: begin
        freeze_pipe = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // A frozen pipeline defers any branch or hazard until it advances.
  always_comb begin
    freeze_if = 1'b0;
    flush_if  = 1'b0;
    bubble_id = 1'b0;
    if (freeze_pipe) begin
      freeze_if = 1'b1;
    end else if (branch_taken) begin
      flush_if  = 1'b1;
      bubble_id = 1'b1;
    end else if (haz) begin
      freeze_if = 1'b1;
      bubble_id = 1'b1;
    end
  end

  assign mem_err = (state_q == ERROR);
  assign state   = state_q;

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles   <= '0;
      perf_stalls   <= '0;
      perf_flushes  <= '0;
      perf_mem_wait <= '0;
    end else begin
      perf_cycles <= perf_cycles + 32'd1;
      if (haz & ~branch_taken & ~freeze_pipe) perf_stalls <= perf_stalls + 32'd1;
      if (flush_if) perf_flushes <= perf_flushes + 32'd1;
      if (freeze_pipe) perf_mem_wait <= perf_mem_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed steps followed by random cycles,
// every output compared against a behavioural model of the controller rules.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       forward_en;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       id_use_src1, id_two_src;
  logic       exe_wb_en, exe_mem_read_en, mem_wb_en;
  logic       branch_taken, mem_req, mem_ready;
  logic       freeze_if, flush_if, bubble_id, freeze_pipe, mem_start, mem_err;
  logic [1:0] stateObs;

  int assertCount = 0;
  int failCount   = 0;

  // Model: is an access outstanding, how long has it waited, has it timed out.
  bit mInWait;
  bit mDead;
  int mWaitCycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read_en(exe_mem_read_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_if(freeze_if), .flush_if(flush_if), .bubble_id(bubble_id),
    .freeze_pipe(freeze_pipe), .mem_start(mem_start), .mem_err(mem_err),
    .state(stateObs)
  );

  // A source conflicts with any in-flight producer the forwarding setup cannot cover.
  function automatic bit modelHaz();
    logic [3:0] srcs [2];
    bit         used [2];
    srcs[0] = id_src1; used[0] = id_use_src1;
    srcs[1] = id_src2; used[1] = id_two_src;
    for (int i = 0; i < 2; i++) begin
      if (!used[i]) continue;
      if (forward_en) begin
        if (exe_mem_read_en && exe_wb_en && srcs[i] == exe_dest) return 1'b1;
      end else begin
        if (exe_wb_en && srcs[i] == exe_dest) return 1'b1;
        if (mem_wb_en && srcs[i] == mem_dest) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    rst = 1'b0; forward_en = 1'b0;
    id_src1 = 4'd0; id_src2 = 4'd0; id_use_src1 = 1'b0; id_two_src = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_read_en = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Checks the current cycle's outputs, then clocks and advances the model.
  task automatic applyStimulus(input string tag);
    bit frozen, eFif, eFlush, eBub, eStart;
    logic [1:0] eState;
    #2;
    frozen = mDead || (mInWait && !mem_ready) || (!mInWait && mem_req);
    eStart = !mDead && !mInWait && mem_req;
    eState = mDead ? 2'd2 : (mInWait ? 2'd1 : 2'd0);
    eFif = 1'b0; eFlush = 1'b0; eBub = 1'b0;
    if (frozen) eFif = 1'b1;
    else if (branch_taken) begin eFlush = 1'b1; eBub = 1'b1; end
    else if (modelHaz()) begin eFif = 1'b1; eBub = 1'b1; end
    checkOutput({tag, ".freeze_if"},   {1'b0, freeze_if},   {1'b0, eFif});
    checkOutput({tag, ".flush_if"},    {1'b0, flush_if},    {1'b0, eFlush});
    checkOutput({tag, ".bubble_id"},   {1'b0, bubble_id},   {1'b0, eBub});
    checkOutput({tag, ".freeze_pipe"}, {1'b0, freeze_pipe}, {1'b0, frozen});
    checkOutput({tag, ".mem_start"},   {1'b0, mem_start},   {1'b0, eStart});
    checkOutput({tag, ".mem_err"},     {1'b0, mem_err},     {1'b0, mDead});
    checkOutput({tag, ".state"},       stateObs,            eState);
    @(posedge clk);
    if (rst) begin
      mInWait = 1'b0; mDead = 1'b0; mWaitCycles = 0;
    end else if (mDead) begin
      mDead = 1'b1;
    end else if (mInWait) begin
      if (mem_ready) begin
        mInWait = 1'b0;
      end else begin
        mWaitCycles++;
        if (mWaitCycles == TIMEOUT) begin
          mInWait = 1'b0; mDead = 1'b1;
        end
      end
    end else if (mem_req) begin
      mInWait = 1'b1; mWaitCycles = 0;
    end
    #1;
  endtask

  initial begin
    clearInputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    mInWait = 1'b0; mDead = 1'b0; mWaitCycles = 0;
    rst = 1'b0;
    applyStimulus("reset");

    // RAW hazards without forwarding, EXE then MEM producer
    id_src1 = 4'd3; id_use_src1 = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
    applyStimulus("hazExe");
    exe_wb_en = 1'b0; mem_dest = 4'd3; mem_wb_en = 1'b1;
    applyStimulus("hazMem");
    mem_wb_en = 1'b0; id_two_src = 1'b1; id_src2 = 4'd7; exe_dest = 4'd7; exe_wb_en = 1'b1;
    applyStimulus("hazSrc2");

    // forwarding: only load-use stalls
    clearInputs();
    forward_en = 1'b1; id_src1 = 4'd3; id_use_src1 = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
    applyStimulus("fwdNoLoad");
    exe_mem_read_en = 1'b1;
    applyStimulus("fwdLoadUse");
    branch_taken = 1'b1;
    applyStimulus("branchOverHaz");

    // memory access with ready on the fourth cycle, then back-to-back access
    clearInputs();
    mem_req = 1'b1;
    applyStimulus("mem1");
    applyStimulus("mem2");
    applyStimulus("mem3");
    mem_ready = 1'b1;
    applyStimulus("mem4");
    mem_ready = 1'b0;
    applyStimulus("memBackToBack");
    mem_ready = 1'b1; mem_req = 1'b0;
    applyStimulus("memBackReady");
    mem_ready = 1'b0;
    applyStimulus("memIdle");

    // branch held during a memory wait
    mem_req = 1'b1; branch_taken = 1'b1;
    applyStimulus("brMemStart");
    applyStimulus("brMemWait");
    mem_ready = 1'b1;
    applyStimulus("brMemReady");
    clearInputs();

    // timeout into the sticky error state, then reset out of it
    mem_req = 1'b1;
    for (int i = 0; i < TIMEOUT + 4; i++) applyStimulus($sformatf("timeout%0d", i));
    mem_ready = 1'b1; branch_taken = 1'b1;
    applyStimulus("errSticky");
    clearInputs();
    rst = 1'b1;
    applyStimulus("errReset");
    rst = 1'b0;
    applyStimulus("afterReset");

    // random traffic with small register indices to provoke collisions
    for (int n = 0; n < 400; n++) begin
      rst             = ($urandom_range(0, 39) == 0);
      forward_en      = 1'($urandom);
      id_src1         = 4'($urandom_range(0, 3));
      id_src2         = 4'($urandom_range(0, 3));
      id_use_src1     = 1'($urandom);
      id_two_src      = 1'($urandom);
      exe_dest        = 4'($urandom_range(0, 3));
      exe_wb_en       = 1'($urandom);
      exe_mem_read_en = 1'($urandom);
      mem_dest        = 4'($urandom_range(0, 3));
      mem_wb_en       = 1'($urandom);
      branch_taken    = ($urandom_range(0, 3) == 0);
      mem_req         = ($urandom_range(0, 2) == 0);
      mem_ready       = ($urandom_range(0, 9) < 3);
      applyStimulus($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
